regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised multi-port register file with a per-register busy scoreboard. It is the successor to the fixed 32-entry, single-enable register bank used by the core.
- Generalised in data width, depth and read/write port count.
- Adds synchronous reset, write-through bypass, and issue/write-back tracking of in-flight destination registers.
- Sits between the decode/issue stage (reads, issue) and the write-back stage (writes, busy clear).

Parameters:
W, 32, data width in bits
DEPTH, 32, number of registers (power of two, >=2)
AW, $clog2(DEPTH), register address width
NR, 2, number of read ports (>=1)
NW, 1, number of write ports (>=1)
ZERO_REG, 1, 1: register 0 is hardwired to zero and never busy; 0: register 0 is ordinary

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
raddr  in  NR*AW  read addresses, port k at bits [k*AW +: AW]
rdata  out  NR*W  read data, port k at bits [k*W +: W]
rbusy  out  NR  busy bit of each read address (after bypass, see below)
we  in  NW  write enable per write port
waddr  in  NW*AW  write addresses
wdata  in  NW*W  write data
issue_valid  in  1  request to mark issue_addr busy
issue_addr  in  AW  destination register being issued
issue_ready  out  1  issue_addr is not busy (WAW-free)
busy_vec  out  DEPTH  current scoreboard state (debug/verification)

Behaviour:
- One clock domain. All state updates on posedge clk. Reset is synchronous and active-high: rst=1 at a posedge clears every register to 0 and every busy bit to 0, overriding all writes and issues that cycle.
- Outputs after reset: rdata=0 for all ports, rbusy=0, issue_ready=1, busy_vec=0.
- Write: for each port j with we[j]=1, mem[waddr_j] <= wdata_j and busy[waddr_j] <= 0 at the posedge.
  - Two ports writing the same address: the highest port index wins, for both data and busy clear.
  - ZERO_REG=1 and waddr=0: no effect.
- Read: combinational, zero-cycle.
  - If raddr_k matches any same-cycle write (we[j]=1, waddr_j==raddr_k), rdata_k = wdata of the highest matching j (bypass) and rbusy_k=0.
  - Otherwise rdata_k = mem[raddr_k] and rbusy_k = busy[raddr_k].
  - ZERO_REG=1 and raddr_k=0: rdata_k=0 and rbusy_k=0 regardless of writes.
- Issue:
  - issue_ready = ~busy[issue_addr]. Same-cycle write-back does NOT make it ready; readiness is registered-state only.
  - issue_ready is forced to 1 when ZERO_REG=1 and issue_addr=0.
  - issue_valid & issue_ready at a posedge sets busy[issue_addr] <= 1.
  - issue_valid with issue_ready=0 is ignored (no state change); the requester must hold.
  - Issue to address 0 with ZERO_REG=1: accepted, busy stays 0.
- Simultaneous issue and write to the same address in one cycle: the set wins. Busy ends at 1; data is still written.
- Latency: write visible to a read the same cycle (bypass) and thereafter from mem. Busy set visible the next cycle.
- Scoreboard holds at most one in-flight write per register (enforced by issue_ready). A write to a non-busy register is legal and leaves busy=0.
- No X on outputs after the first reset. Addresses >= DEPTH cannot occur (DEPTH is a power of two).

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then read all addresses -> rdata=0, busy_vec=0, issue_ready=1.
2. Write/read and bypass: we[0]=1, waddr=5, wdata=32'hDEADBEEF, raddr0=5 in the same cycle -> rdata0=DEADBEEF combinationally. Next cycle with we=0 -> still DEADBEEF.
3. Zero register (ZERO_REG=1): write 32'h1234 to addr 0, issue addr 0 -> rdata=0, rbusy=0, busy_vec[0]=0, issue_ready stays 1.
4. Scoreboard: issue addr 7 -> next cycle busy_vec[7]=1 and issue_ready=0 for addr 7. Re-issue 7 -> ignored. Write-back 7 with 32'hA5 -> same cycle rbusy=0 and rdata=A5, but issue_ready=0. Next cycle busy_vec[7]=0 and issue_ready=1.
5. Conflicts (NW=2): both ports write addr 3 with 11 and 22 -> mem[3]=22. Issue and write-back addr 9 in one cycle -> busy[9]=1 and data written.
6. Reset mid-operation: registers 1..4 busy with data written, assert rst together with a write and an issue -> all data=0 and busy_vec=0 next cycle; the concurrent write and issue are discarded.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-port register file with a per-register
// busy scoreboard. Writes clear busy, accepted issues set it, and reads see
// same-cycle writes through a combinational bypass.
module regfile_sb #(
   parameter int W        = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int NR       = 2,
   parameter int NW       = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NR*AW-1:0]  raddr,
   output logic [NR*W-1:0]   rdata,
   output logic [NR-1:0]     rbusy,
   input  logic [NW-1:0]     we,
   input  logic [NW*AW-1:0]  waddr,
   input  logic [NW*W-1:0]   wdata,
   input  logic              issue_valid,
   input  logic [AW-1:0]     issue_addr,
   output logic              issue_ready,
   output logic [DEPTH-1:0]  busy_vec
);

   localparam bit ZeroEn = (ZERO_REG != 0);

   logic [W-1:0]     mem_q  [DEPTH];
   logic [W-1:0]     mem_d  [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   logic [AW-1:0] raddr_a [NR];
   logic [AW-1:0] waddr_a [NW];
   logic [W-1:0]  wdata_a [NW];

   // Unpack the flat port buses into per-port views.
   for (genvar k = 0; k < NR; k++) begin : g_rd_unpack
      assign raddr_a[k] = raddr[k*AW +: AW];
   end
   for (genvar j = 0; j < NW; j++) begin : g_wr_unpack
      assign waddr_a[j] = waddr[j*AW +: AW];
      assign wdata_a[j] = wdata[j*W +: W];
   end

   // Readiness looks only at registered busy state; a same-cycle
   // write-back does not make the destination issuable yet.
   assign issue_ready = ~busy_q[issue_addr] | (ZeroEn && (issue_addr == '0));
   assign busy_vec    = busy_q;

   // Next-state for data and busy: writes in ascending port order so the
   // highest port wins, then an accepted issue sets busy on top of any clear.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int j = 0; j < NW; j++) begin
         if (we[j] && !(ZeroEn && (waddr_a[j] == '0))) begin
            // NOTE: combinational logic uses blocking '=', so later
            // iterations see and override earlier ones within this block.
            mem_d[waddr_a[j]]  = wdata_a[j];
            busy_d[waddr_a[j]] = 1'b0;
         end
      end
      if (issue_valid && issue_ready && !(ZeroEn && (issue_addr == '0))) begin
         busy_d[issue_addr] = 1'b1;
      end
   end

   // Combinational read ports with write-through bypass and zero register.
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int k = 0; k < NR; k++) begin
         rdata[k*W +: W] = mem_q[raddr_a[k]];
         rbusy[k]        = busy_q[raddr_a[k]];
         for (int j = 0; j < NW; j++) begin
            if (we[j] && (waddr_a[j] == raddr_a[k])) begin
               rdata[k*W +: W] = wdata_a[j];
               rbusy[k]        = 1'b0;
            end
         end
         if (ZeroEn && (raddr_a[k] == '0)) begin
            rdata[k*W +: W] = '0;
            rbusy[k]        = 1'b0;
         end
      end
   end

   // State registers; synchronous reset clears data and scoreboard and
   // overrides any write or issue presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the register array is reset on purpose: the contents are
         // architecturally visible and must read as zero after reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking '<=' so all registers
         // update together from values sampled at the same edge.
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a
// behavioural array model of the register file and scoreboard.
module tb_regfile_sb;

   localparam int W     = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NW    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AW-1:0]  raddr;
   logic [NR*W-1:0]   rdata;
   logic [NR-1:0]     rbusy;
   logic [NW-1:0]     we;
   logic [NW*AW-1:0]  waddr;
   logic [NW*W-1:0]   wdata;
   logic              issue_valid;
   logic [AW-1:0]     issue_addr;
   logic              issue_ready;
   logic [DEPTH-1:0]  busy_vec;

   int total = 0;
   int bad   = 0;

   // Behavioural model: plain arrays of register contents and busy flags.
   logic [W-1:0] ref_mem  [DEPTH];
   bit           ref_busy [DEPTH];

   regfile_sb #(
      .W(W), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .raddr       (raddr),
      .rdata       (rdata),
      .rbusy       (rbusy),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .busy_vec    (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst         = 1'b0;
      we          = '0;
      waddr       = '0;
      wdata       = '0;
      issue_valid = 1'b0;
      issue_addr  = '0;
      raddr       = '0;
   endtask

   // Compare every output with what the model says for the current inputs.
   task automatic check_model(input string tag);
      logic [W-1:0]     e_d;
      bit               e_b;
      logic [AW-1:0]    a;
      logic [DEPTH-1:0] e_vec;
      bit               e_rdy;
      for (int k = 0; k < NR; k++) begin
         a   = raddr[k*AW +: AW];
         e_d = ref_mem[a];
         e_b = ref_busy[a];
         for (int j = 0; j < NW; j++) begin
            if (we[j] && waddr[j*AW +: AW] == a) begin
               e_d = wdata[j*W +: W];
               e_b = 1'b0;
            end
         end
         if (a == 0) begin
            e_d = '0;
            e_b = 1'b0;
         end
         check($sformatf("%s_rdata%0d", tag, k), rdata[k*W +: W], e_d);
         check($sformatf("%s_rbusy%0d", tag, k), rbusy[k], e_b);
      end
      for (int i = 0; i < DEPTH; i++) e_vec[i] = ref_busy[i];
      e_rdy = (issue_addr == 0) || !ref_busy[issue_addr];
      check({tag, "_busy_vec"}, busy_vec, e_vec);
      check({tag, "_issue_ready"}, issue_ready, e_rdy);
   endtask

   // Advance one clock and apply the architectural rules to the model.
   task automatic tick();
      bit accept;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = '0;
            ref_busy[i] = 1'b0;
         end
      end else begin
         accept = issue_valid && ((issue_addr == 0) || !ref_busy[issue_addr]);
         for (int j = 0; j < NW; j++) begin
            if (we[j] && waddr[j*AW +: AW] != 0) begin
               ref_mem[waddr[j*AW +: AW]]  = wdata[j*W +: W];
               ref_busy[waddr[j*AW +: AW]] = 1'b0;
            end
         end
         if (accept && issue_addr != 0) ref_busy[issue_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]  = 'x;
         ref_busy[i] = 1'b0;
      end
      idle();
      @(negedge clk);

      // 1. Reset held two cycles, then every address reads zero.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int a = 0; a < DEPTH; a += 2) begin
         raddr = {5'(a + 1), 5'(a)};
         issue_addr = 5'(a);
         #1;
         check($sformatf("rst_rd_a%0d", a), rdata, '0);
         check($sformatf("rst_busy_a%0d", a), rbusy, '0);
         check($sformatf("rst_ready_a%0d", a), issue_ready, 1'b1);
      end
      check("rst_busy_vec", busy_vec, '0);

      // 2. Write with same-cycle bypass, then from storage.
      idle();
      we[0] = 1'b1; waddr[0 +: AW] = 5'd5; wdata[0 +: W] = 32'hDEADBEEF;
      raddr[0 +: AW] = 5'd5;
      #1;
      check("wr_bypass", rdata[0 +: W], 32'hDEADBEEF);
      check_model("wr_bypass_m");
      tick();
      we = '0;
      #1;
      check("wr_stored", rdata[0 +: W], 32'hDEADBEEF);

      // 3. Register zero ignores writes and issues.
      idle();
      we[0] = 1'b1; waddr[0 +: AW] = 5'd0; wdata[0 +: W] = 32'h1234;
      issue_valid = 1'b1; issue_addr = 5'd0;
      #1;
      check("z_rdata", rdata[0 +: W], '0);
      check("z_rbusy", rbusy[0], 1'b0);
      check("z_ready", issue_ready, 1'b1);
      tick();
      idle();
      #1;
      check("z_rdata_after", rdata[0 +: W], '0);
      check("z_busy0", busy_vec[0], 1'b0);
      check("z_ready_after", issue_ready, 1'b1);

      // 4. Scoreboard: issue, blocked re-issue, write-back, release.
      issue_valid = 1'b1; issue_addr = 5'd7; raddr[0 +: AW] = 5'd7;
      #1;
      check("sb_ready_pre", issue_ready, 1'b1);
      tick();
      #1;
      check("sb_busy7", busy_vec[7], 1'b1);
      check("sb_ready7", issue_ready, 1'b0);
      check("sb_rbusy7", rbusy[0], 1'b1);
      tick();   // re-issue while busy is ignored
      #1;
      check("sb_reissue_vec", busy_vec, 32'h0000_0080);
      issue_valid = 1'b0;
      we[0] = 1'b1; waddr[0 +: AW] = 5'd7; wdata[0 +: W] = 32'hA5;
      #1;
      check("sb_wb_rbusy", rbusy[0], 1'b0);
      check("sb_wb_rdata", rdata[0 +: W], 32'hA5);
      check("sb_wb_ready", issue_ready, 1'b0);
      tick();
      we = '0;
      #1;
      check("sb_rel_busy7", busy_vec[7], 1'b0);
      check("sb_rel_ready", issue_ready, 1'b1);

      // 5. Conflicts: two ports on one address; issue and write-back together.
      idle();
      we = 2'b11;
      waddr = {5'd3, 5'd3};
      wdata = {32'd22, 32'd11};
      raddr[0 +: AW] = 5'd3;
      #1;
      check("cf_bypass_hi", rdata[0 +: W], 32'd22);
      tick();
      we = '0;
      #1;
      check("cf_mem3", rdata[0 +: W], 32'd22);
      we[0] = 1'b1; waddr[0 +: AW] = 5'd9; wdata[0 +: W] = 32'h99;
      issue_valid = 1'b1; issue_addr = 5'd9; raddr[AW +: AW] = 5'd9;
      tick();
      idle();
      raddr[AW +: AW] = 5'd9;
      #1;
      check("cf_busy9", busy_vec[9], 1'b1);
      check("cf_data9", rdata[W +: W], 32'h99);
      check("cf_rbusy9", rbusy[1], 1'b1);

      // 6. Reset in the middle of activity discards concurrent write/issue.
      for (int a = 1; a <= 4; a++) begin
         idle();
         we[1] = 1'b1; waddr[AW +: AW] = 5'(a); wdata[W +: W] = 32'(a * 100);
         tick();
         idle();
         issue_valid = 1'b1; issue_addr = 5'(a);
         tick();
      end
      idle();
      raddr = {5'd4, 5'd1};
      #1;
      check("mr_pre_vec", busy_vec, 32'h0000_0200 | 32'h0000_001E);
      check("mr_pre_data", rdata[W +: W], 32'd400);
      rst = 1'b1;
      we[0] = 1'b1; waddr[0 +: AW] = 5'd10; wdata[0 +: W] = 32'hCAFE;
      issue_valid = 1'b1; issue_addr = 5'd11;
      tick();
      idle();
      raddr = {5'd10, 5'd2};
      issue_addr = 5'd11;
      #1;
      check("mr_vec", busy_vec, '0);
      check("mr_data", rdata, '0);
      check("mr_ready", issue_ready, 1'b1);

      // Randomized traffic against the model, with occasional resets.
      for (int c = 0; c < 400; c++) begin
         idle();
         rst = ($urandom_range(0, 49) == 0);
         for (int j = 0; j < NW; j++) begin
            we[j] = ($urandom_range(0, 2) == 0);
            waddr[j*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            wdata[j*W +: W]   = $urandom;
         end
         issue_valid = $urandom_range(0, 1) == 1;
         issue_addr  = AW'($urandom_range(0, DEPTH - 1));
         for (int k = 0; k < NR; k++) begin
            raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr[0 +: AW]
                                                            : AW'($urandom_range(0, DEPTH - 1));
         end
         #1;
         check_model($sformatf("rnd%0d", c));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
